// File: rtl/lisnoc_pkg.sv
// Shared types for the LISNoC virtual-channel packet buffer.
// The flit-type encodings match the FLIT_TYPE_* macros in lisnoc_def.vh.
package lisnoc_pkg;

    typedef enum logic [1:0] {
        FLIT_TYPE_PAYLOAD = 2'b00,
        FLIT_TYPE_HEADER  = 2'b01,
        FLIT_TYPE_LAST    = 2'b10,
        FLIT_TYPE_SINGLE  = 2'b11
    } flit_type_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_ACTIVE
    } arb_state_e;

    function automatic int flit_width_of(input int data_width);
        return data_width + 2;
    endfunction

    function automatic logic is_last_type(input logic [1:0] flit_type);
        return (flit_type == FLIT_TYPE_LAST) || (flit_type == FLIT_TYPE_SINGLE);
    endfunction

endpackage

// File: rtl/lisnoc_vc_packet_fifo.sv
// One virtual channel's circular FIFO. It tracks how many complete packets are
// stored, the length of the head packet, and whether the VC may be arbitrated.
module lisnoc_vc_packet_fifo
    import lisnoc_pkg::*;
#(
    parameter int  data_width = 32,
    parameter int  fifo_depth = 16,
    localparam int flit_width = flit_width_of(data_width),
    localparam int size_width = $clog2(fifo_depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [flit_width-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [flit_width-1:0] out_flit,
    output logic                  out_last,
    input  logic                  pop,
    output logic                  empty,
    output logic [size_width-1:0] out_size,
    output logic                  eligible
);

    localparam int ptr_width = $clog2(fifo_depth);

    logic [flit_width-1:0] mem [fifo_depth];
    logic [fifo_depth-1:0] last_bits;
    logic [ptr_width-1:0]  rd_ptr;
    logic [ptr_width-1:0]  wr_ptr;
    logic [size_width-1:0] count;
    logic [size_width-1:0] pkt_cnt;
    logic                  full;
    logic                  push;
    logic                  in_last;
    int                    idx;

    function automatic logic [ptr_width-1:0] next_ptr(input logic [ptr_width-1:0] p);
        return (p == ptr_width'(fifo_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_last  = is_last_type(in_flit[flit_width-1 -: 2]);
    assign full     = (count == size_width'(fifo_depth));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign out_flit = mem[rd_ptr];
    assign out_last = last_bits[rd_ptr];
    // A full FIFO with no complete packet can only drain by cut-through.
    assign eligible = (pkt_cnt != '0) || full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pkt_cnt   <= '0;
            last_bits <= '0;
        end else begin
            if (push) begin
                last_bits[wr_ptr] <= in_last;
                wr_ptr            <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if ((push && in_last) && !(pop && out_last)) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end else if (!(push && in_last) && (pop && out_last)) begin
                pkt_cnt <= pkt_cnt - 1'b1;
            end
        end
    end

    // Scan from the far end towards the head so the nearest last flit wins.
    always_comb begin
        out_size = '0;
        idx      = 0;
        for (int i = fifo_depth - 1; i >= 0; i--) begin
            idx = int'(rd_ptr) + i;
            if (idx >= fifo_depth) begin
                idx = idx - fifo_depth;
            end
            if ((pkt_cnt != '0) && (i < int'(count)) && last_bits[idx[ptr_width-1:0]]) begin
                out_size = size_width'(i + 1);
            end
        end
    end

endmodule

// File: rtl/lisnoc_vc_packet_buffer.sv
// Store-and-forward buffer with per-VC FIFOs and a round-robin arbiter that
// holds one VC on the shared output bus until its packet's last flit leaves.
module lisnoc_vc_packet_buffer
    import lisnoc_pkg::*;
#(
    parameter int  data_width = 32,
    parameter int  fifo_depth = 16,
    parameter int  vchannels  = 2,
    localparam int flit_width = flit_width_of(data_width),
    localparam int size_width = $clog2(fifo_depth + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [flit_width-1:0]           in_flit,
    input  logic [vchannels-1:0]            in_valid,
    output logic [vchannels-1:0]            in_ready,
    output logic [flit_width-1:0]           out_flit,
    output logic [vchannels-1:0]            out_valid,
    input  logic [vchannels-1:0]            out_ready,
    output logic [vchannels*size_width-1:0] out_size
);

    localparam int vc_width = (vchannels > 1) ? $clog2(vchannels) : 1;

    logic [flit_width-1:0] head_flit [vchannels];
    logic [vchannels-1:0]  head_last;
    logic [vchannels-1:0]  empty;
    logic [vchannels-1:0]  eligible;
    logic [vchannels-1:0]  pop;
    arb_state_e            state;
    logic [vc_width-1:0]   grant;
    logic [vc_width-1:0]   rr_ptr;
    logic [vc_width-1:0]   next_grant;
    logic                  any_eligible;
    int                    cand;

    for (genvar v = 0; v < vchannels; v++) begin : gen_vc
        lisnoc_vc_packet_fifo #(
            .data_width (data_width),
            .fifo_depth (fifo_depth)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .in_flit  (in_flit),
            .in_valid (in_valid[v]),
            .in_ready (in_ready[v]),
            .out_flit (head_flit[v]),
            .out_last (head_last[v]),
            .pop      (pop[v]),
            .empty    (empty[v]),
            .out_size (out_size[v*size_width +: size_width]),
            .eligible (eligible[v])
        );
    end

    // Walk the candidates from furthest to nearest after rr_ptr so the nearest
    // eligible VC is the one left in next_grant.
    always_comb begin
        next_grant   = grant;
        any_eligible = 1'b0;
        cand         = 0;
        for (int k = vchannels; k >= 1; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= vchannels) begin
                cand = cand - vchannels;
            end
            if (eligible[cand[vc_width-1:0]]) begin
                next_grant   = cand[vc_width-1:0];
                any_eligible = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_flit  = '0;
        if (state == ARB_ACTIVE) begin
            out_valid[grant] = !empty[grant];
            out_flit         = head_flit[grant];
        end
    end

    assign pop = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= vc_width'(vchannels - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_eligible) begin
                        grant <= next_grant;
                        state <= ARB_ACTIVE;
                    end
                end
                ARB_ACTIVE: begin
                    if (pop[grant] && head_last[grant]) begin
                        rr_ptr <= grant;
                        state  <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lisnoc_vc_packet_buffer.sv
// Directed bench for the VC packet buffer: a per-cycle vector table plus
// hand-written full/drain and oversize cut-through sequences.
module tb_lisnoc_vc_packet_buffer;

    localparam int FW = 34;
    localparam int VC = 2;
    localparam int SW = 5;

    localparam logic [1:0] T_PAY = 2'b00;
    localparam logic [1:0] T_HDR = 2'b01;
    localparam logic [1:0] T_LST = 2'b10;
    localparam logic [1:0] T_SGL = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic [FW-1:0]    in_flit;
    logic [VC-1:0]    in_valid;
    logic [VC-1:0]    in_ready;
    logic [FW-1:0]    out_flit;
    logic [VC-1:0]    out_valid;
    logic [VC-1:0]    out_ready;
    logic [VC*SW-1:0] out_size;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string         name;
        logic          rst;
        logic [1:0]    in_valid;
        logic [FW-1:0] in_flit;
        logic [1:0]    out_ready;
        logic [1:0]    exp_valid;
        logic          chk_flit;
        logic [FW-1:0] exp_flit;
        logic [1:0]    exp_in_ready;
        logic [9:0]    exp_size;
    } vec_t;

    vec_t vecs[$];

    lisnoc_vc_packet_buffer #(
        .data_width (32),
        .fifo_depth (16),
        .vchannels  (VC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_size  (out_size)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [FW-1:0] fl(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    function automatic logic [1:0] ovType(input int k);
        if (k == 0) return T_HDR;
        if (k == 19) return T_LST;
        return T_PAY;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic r, input logic [1:0] iv,
                          input logic [FW-1:0] iflit, input logic [1:0] ordy,
                          input logic [1:0] ev, input logic cf, input logic [FW-1:0] ef,
                          input logic [1:0] eir, input logic [9:0] es);
        vec_t v;
        v.name = name; v.rst = r; v.in_valid = iv; v.in_flit = iflit; v.out_ready = ordy;
        v.exp_valid = ev; v.chk_flit = cf; v.exp_flit = ef; v.exp_in_ready = eir; v.exp_size = es;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        in_valid  = v.in_valid;
        in_flit   = v.in_flit;
        out_ready = v.out_ready;
    endtask

    task automatic checkOutput(input vec_t v);
        check($sformatf("%s.out_valid", v.name), out_valid, v.exp_valid);
        check($sformatf("%s.in_ready", v.name), in_ready, v.exp_in_ready);
        check($sformatf("%s.out_size", v.name), out_size, v.exp_size);
        if (v.chk_flit) begin
            check($sformatf("%s.out_flit", v.name), out_flit, v.exp_flit);
        end
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [FW-1:0] got[$];
        logic [FW+1:0] rx[$];
        int            sent;
        bit            vc1_sent;

        rst = 1'b1; in_valid = '0; in_flit = '0; out_ready = '0;
        nextCycle;
        nextCycle;
        @(negedge clk);
        check("reset.out_valid", out_valid, 2'b00);
        check("reset.in_ready", in_ready, 2'b11);
        check("reset.out_size", out_size, 10'd0);
        check("reset.out_flit", out_flit, '0);
        nextCycle;

        // Single VC, 3-flit packet
        addVec("a0", 0, 2'b01, fl(T_HDR, 32'hA0), 2'b01, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("a1", 0, 2'b01, fl(T_PAY, 32'hA1), 2'b01, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("a2", 0, 2'b01, fl(T_LST, 32'hA2), 2'b01, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("a3", 0, 2'b00, '0, 2'b01, 2'b00, 0, '0, 2'b11, 10'd3);
        addVec("a4", 0, 2'b00, '0, 2'b01, 2'b01, 1, fl(T_HDR, 32'hA0), 2'b11, 10'd3);
        addVec("a5", 0, 2'b00, '0, 2'b01, 2'b01, 1, fl(T_PAY, 32'hA1), 2'b11, 10'd2);
        addVec("a6", 0, 2'b00, '0, 2'b01, 2'b01, 1, fl(T_LST, 32'hA2), 2'b11, 10'd1);
        addVec("a7", 0, 2'b00, '0, 2'b01, 2'b00, 0, '0, 2'b11, 10'd0);
        // Two VCs, round robin, then a further VC0 packet
        addVec("b0", 1, 2'b00, '0, 2'b00, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("b1", 0, 2'b01, fl(T_HDR, 32'hB0), 2'b00, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("b2", 0, 2'b01, fl(T_LST, 32'hB1), 2'b00, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("b3", 0, 2'b10, fl(T_HDR, 32'hC0), 2'b00, 2'b00, 0, '0, 2'b11, 10'd2);
        addVec("b4", 0, 2'b10, fl(T_LST, 32'hC1), 2'b00, 2'b01, 1, fl(T_HDR, 32'hB0), 2'b11, 10'd2);
        addVec("b5", 0, 2'b00, '0, 2'b11, 2'b01, 1, fl(T_HDR, 32'hB0), 2'b11, 10'd66);
        addVec("b6", 0, 2'b01, fl(T_SGL, 32'hD0), 2'b11, 2'b01, 1, fl(T_LST, 32'hB1), 2'b11, 10'd65);
        addVec("b7", 0, 2'b00, '0, 2'b11, 2'b00, 0, '0, 2'b11, 10'd65);
        addVec("b8", 0, 2'b00, '0, 2'b11, 2'b10, 1, fl(T_HDR, 32'hC0), 2'b11, 10'd65);
        addVec("b9", 0, 2'b00, '0, 2'b11, 2'b10, 1, fl(T_LST, 32'hC1), 2'b11, 10'd33);
        addVec("b10", 0, 2'b00, '0, 2'b11, 2'b00, 0, '0, 2'b11, 10'd1);
        addVec("b11", 0, 2'b00, '0, 2'b11, 2'b01, 1, fl(T_SGL, 32'hD0), 2'b11, 10'd1);
        addVec("b12", 0, 2'b00, '0, 2'b11, 2'b00, 0, '0, 2'b11, 10'd0);
        // Backpressure stability while VC1 is granted
        addVec("e0", 1, 2'b00, '0, 2'b00, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("e1", 0, 2'b10, fl(T_SGL, 32'hE0), 2'b00, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("e2", 0, 2'b01, fl(T_HDR, 32'hF0), 2'b00, 2'b00, 0, '0, 2'b11, 10'd32);
        addVec("e3", 0, 2'b01, fl(T_LST, 32'hF1), 2'b00, 2'b10, 1, fl(T_SGL, 32'hE0), 2'b11, 10'd32);
        addVec("e4", 0, 2'b00, '0, 2'b00, 2'b10, 1, fl(T_SGL, 32'hE0), 2'b11, 10'd34);
        addVec("e5", 0, 2'b00, '0, 2'b00, 2'b10, 1, fl(T_SGL, 32'hE0), 2'b11, 10'd34);
        addVec("e6", 0, 2'b00, '0, 2'b00, 2'b10, 1, fl(T_SGL, 32'hE0), 2'b11, 10'd34);
        addVec("e7", 0, 2'b00, '0, 2'b00, 2'b10, 1, fl(T_SGL, 32'hE0), 2'b11, 10'd34);
        addVec("e8", 0, 2'b00, '0, 2'b10, 2'b10, 1, fl(T_SGL, 32'hE0), 2'b11, 10'd34);
        addVec("e9", 0, 2'b00, '0, 2'b01, 2'b00, 0, '0, 2'b11, 10'd2);
        addVec("e10", 0, 2'b00, '0, 2'b01, 2'b01, 1, fl(T_HDR, 32'hF0), 2'b11, 10'd2);
        addVec("e11", 0, 2'b00, '0, 2'b01, 2'b01, 1, fl(T_LST, 32'hF1), 2'b11, 10'd1);
        addVec("e12", 0, 2'b00, '0, 2'b00, 2'b00, 0, '0, 2'b11, 10'd0);
        // Reset after 2 of 4 flits, then a fresh packet
        addVec("r0", 1, 2'b00, '0, 2'b00, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("r1", 0, 2'b01, fl(T_HDR, 32'h60), 2'b00, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("r2", 0, 2'b01, fl(T_PAY, 32'h61), 2'b00, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("r3", 1, 2'b00, '0, 2'b00, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("r4", 0, 2'b01, fl(T_SGL, 32'h70), 2'b01, 2'b00, 0, '0, 2'b11, 10'd0);
        addVec("r5", 0, 2'b00, '0, 2'b01, 2'b00, 0, '0, 2'b11, 10'd1);
        addVec("r6", 0, 2'b00, '0, 2'b01, 2'b01, 1, fl(T_SGL, 32'h70), 2'b11, 10'd1);
        addVec("r7", 0, 2'b00, '0, 2'b00, 2'b00, 0, '0, 2'b11, 10'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i]);
            nextCycle;
        end

        // Fill VC1 with 16 single flits while downstream is stalled
        rst = 1'b1; in_valid = '0; in_flit = '0; out_ready = '0;
        nextCycle;
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            in_valid = 2'b10;
            in_flit  = fl(T_SGL, 32'h200 + k);
            nextCycle;
        end
        in_valid = '0;
        in_flit  = '0;
        @(negedge clk);
        check("full.in_ready", in_ready, 2'b01);
        check("full.out_valid", out_valid, 2'b10);
        check("full.out_flit", out_flit, fl(T_SGL, 32'h200));
        check("full.out_size", out_size, 10'd32);
        nextCycle;
        in_valid  = 2'b10;
        in_flit   = fl(T_SGL, 32'hDEAD);
        out_ready = 2'b10;
        @(negedge clk);
        check("full.pulse.in_ready", in_ready, 2'b01);
        nextCycle;
        in_valid  = '0;
        in_flit   = '0;
        out_ready = '0;
        @(negedge clk);
        check("drain.in_ready", in_ready, 2'b11);
        check("drain.bubble", out_valid, 2'b00);
        nextCycle;
        out_ready = 2'b10;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid[1]) got.push_back(out_flit);
            nextCycle;
        end
        check("drain.count", got.size(), 15);
        for (int i = 0; i < got.size() && i < 15; i++) begin
            check($sformatf("drain.flit%0d", i), got[i], fl(T_SGL, 32'h201 + i));
        end

        // Oversize 20-flit packet on VC0 with VC1 traffic arriving behind it
        out_ready = '0;
        rst = 1'b1;
        nextCycle;
        rst = 1'b0;
        sent = 0;
        vc1_sent = 1'b0;
        for (int c = 0; c < 120 && rx.size() < 21; c++) begin
            in_valid  = '0;
            in_flit   = '0;
            out_ready = 2'b11;
            if (sent < 20 && in_ready[0]) begin
                in_valid = 2'b01;
                in_flit  = fl(ovType(sent), 32'h100 + sent);
                sent++;
            end else if (!vc1_sent && sent >= 16) begin
                in_valid = 2'b10;
                in_flit  = fl(T_SGL, 32'h300);
                vc1_sent = 1'b1;
            end
            @(negedge clk);
            if (out_valid != 2'b00) rx.push_back({out_valid, out_flit});
            nextCycle;
        end
        in_valid  = '0;
        out_ready = '0;
        check("oversize.count", rx.size(), 21);
        for (int i = 0; i < rx.size() && i < 21; i++) begin
            if (i < 20) begin
                check($sformatf("oversize.flit%0d", i), rx[i], {2'b01, fl(ovType(i), 32'h100 + i)});
            end else begin
                check("oversize.vc1_after", rx[i], {2'b10, fl(T_SGL, 32'h300)});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lisnoc_vc_packet_buffer.md
# lisnoc_vc_packet_buffer

Store-and-forward packet buffer with `vchannels` independent virtual-channel queues sharing one flit bus per direction. Each VC buffers flits in its own circular FIFO and offers a packet downstream only once the packet's last flit is stored. A round-robin arbiter picks one eligible VC and holds it until that packet's last flit leaves. Oversize packets, which can never complete inside the FIFO, fall back to cut-through so they cannot deadlock. Sits between a router output port and a NIC/link with per-VC flow control.

## Interface
- `data_width`, 32, payload bits per flit; `flit_width = data_width+2`, with type in the top two bits.
- `fifo_depth`, 16, flits per VC; any value ≥ 2, need not be a power of two.
- `vchannels`, 2, number of VCs (≥ 1).
- `size_width`, `$clog2(fifo_depth+1)`, localparam.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_flit` in `flit_width`: input flit, shared by all VCs.
- `in_valid` in `vchannels`: per-VC valid; at most one bit set.
- `in_ready` out `vchannels`: per-VC ready.
- `out_flit` out `flit_width`: head flit of the granted VC.
- `out_valid` out `vchannels`: one-hot or zero.
- `out_ready` in `vchannels`: per-VC downstream ready.
- `out_size` out `vchannels*size_width`: per-VC head-packet length in flits; 0 if no complete packet.

## Operation
- Push[v] = in_valid[v] & in_ready[v]. Pop[v] = out_valid[v] & out_ready[v].
- in_ready[v] = !full[v]. A full VC does not accept a push, even when it pops in the same cycle.
- Last flit: type `FLIT_TYPE_LAST` or `FLIT_TYPE_SINGLE`.
- Per VC storage:
  - rd/wr pointers wrap at `fifo_depth`.
  - Occupancy counter 0..fifo_depth.
  - Per-entry last bit.
  - `pkt_cnt[v]`: +1 on push of a last flit, −1 on pop of a last flit; unchanged when both happen in the same cycle.
- Eligible[v] = pkt_cnt[v] > 0, or (full[v] and pkt_cnt[v] == 0), the oversize fallback.
- `out_size[v]`: distance from head to the first last-bit entry, +1; 0 when pkt_cnt[v] == 0.
- Arbiter FSM:
  - IDLE: all out_valid = 0. If any VC is eligible, register `grant` = first eligible VC strictly after `rr_ptr` (cyclic), then go to ACTIVE.
  - ACTIVE: out_valid[grant] = !empty[grant]; other bits are 0. out_flit = head of grant.
    - On pop of a last flit: `rr_ptr` ← grant, go to IDLE.
    - Non-last pops stay in ACTIVE. An oversize packet streams as it arrives; out_valid drops while that VC is empty.
- out_valid, once asserted, is not withdrawn until the flit is popped. The only exception is reset.
- Other VCs keep accepting input while one VC is granted.

## Timing
- Reset values:
  - out_valid = 0.
  - in_ready = all 1.
  - out_size = 0.
  - out_flit is don't-care; implementations drive 0.
  - FSM = IDLE; rr_ptr = vchannels−1, so VC0 wins first.
  - All pointers, counters, pkt_cnt and last bits are cleared.
- Reset mid-packet discards all stored flits; no partial packet survives.
- A last flit pushed in cycle N makes the VC eligible at N+1. The grant registers at the N+1 edge, and out_valid is high in cycle N+2.
- In ACTIVE, one flit per cycle while out_ready is held.
- Between packets there is one IDLE bubble cycle.
- out_flit and out_valid are combinational from registered state. There is no combinational path from in_* to out_*.
- in_ready depends only on registered state, not on out_ready.

## Structure
- `lisnoc_def.vh` keeps the `FLIT_TYPE_*` macros. Add a package `lisnoc_pkg` holding:
  - the flit-type enum;
  - the `flit_width` derivation helper;
  - the FSM state typedef (IDLE/ACTIVE).
- Sub-module `lisnoc_vc_packet_fifo`, instantiated once per VC. It provides:
  - circular storage with last bits;
  - full/empty flags;
  - pkt_cnt and out_size;
  - the eligible flag.
- The top level holds the arbiter FSM, rr_ptr, grant, and the output mux.

## Test plan
- **Single VC, 3-flit packet.** Push HEADER, PAYLOAD, LAST on VC0 with out_ready=1. Required: out_valid stays 0 until 2 cycles after LAST, then 0b01 for 3 consecutive cycles with flits in order. out_size[0] reads 3 before the first pop.
- **Two VCs, round-robin.** Complete 2-flit packets on both VCs, loaded before out_ready rises. Required output order: VC0 packet, 1 bubble, VC1 packet. A further VC0 packet follows the VC1 packet.
- **Full, then drain.** Fill VC1 with 16 SINGLE flits, holding out_ready=0. Required: in_ready[1]=0, pkt_cnt=16. Then pulse out_ready for one cycle: in_ready[1] returns to 1 on the next cycle, and a simultaneous push while full is refused.
- **Oversize fallback.** Send a 20-flit packet into VC0 with depth 16. Required: at full with pkt_cnt=0, VC0 becomes eligible and streams. All 20 flits arrive intact and in order, and VC1 traffic is blocked until that packet's LAST is popped.
- **Backpressure stability.** With out_valid=0b10, hold out_ready=0 for 5 cycles while VC0 completes a packet. Required: out_valid and out_flit stay constant and the grant does not switch.
- **Reset mid-packet.** Assert rst for 1 cycle after 2 of 4 flits. Required: the next cycle shows out_valid=0, in_ready=all 1, out_size=0; a new packet then flows normally.
